// File: rtl/instruction_loader_pkg.sv
// Shared types and defaults for the instruction loader.
// FSM state encoding, byte width and default sizes.
package instruction_loader_pkg;

  localparam int BYTE_SIZE = 8;
  localparam int DEF_WORD_SIZE_IN_BYTES = 4;
  localparam int DEF_MEM_SIZE_IN_WORDS = 64;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_EMPTY,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Byte assembler: shifts bytes in MSB-first and flags the last byte.
// Ports: i_clk, i_reset, i_clear, i_valid, i_byte -> o_word, o_word_valid.
module byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = DEF_WORD_SIZE_IN_BYTES
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_clear,
  input  logic                                     i_valid,
  input  logic [BYTE_SIZE-1:0]                     i_byte,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]  o_word,
  output logic                                     o_word_valid
);

  localparam int BUS = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int CNT_W =
    (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SIZE_IN_BYTES - 1);

  logic [BUS-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUS-1:0]   shifted;
  logic             last;

  // The completed word is presented combinationally so the loader
  // can latch it on the very edge that accepts the last byte.
  assign shifted = (sh_q << BYTE_SIZE) | BUS'(i_byte);
  assign last = (cnt_q == LAST);
  assign o_word = shifted;
  assign o_word_valid = i_valid && last && !i_clear;

  always_comb begin
    sh_d = sh_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      sh_d = '0;
      cnt_d = '0;
    end else if (i_valid) begin
      sh_d = shifted;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from a UART byte stream into IF instruction memory.
// Ports: i_start/i_rx_*/i_mem_* in; o_clear/write_mem, o_instruction, status out.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = DEF_WORD_SIZE_IN_BYTES,
  parameter int MEM_SIZE_IN_WORDS = DEF_MEM_SIZE_IN_WORDS,
  parameter logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] HALT_WORD =
    DEF_HALT_WORD
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic                                        i_start,
  input  logic                                        i_rx_valid,
  input  logic [BYTE_SIZE-1:0]                        i_rx_data,
  input  logic                                        i_mem_full,
  input  logic                                        i_mem_empty,
  output logic                                        o_clear_mem,
  output logic                                        o_write_mem,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]     o_instruction,
  output logic                                        o_busy,
  output logic                                        o_done,
  output logic                                        o_error,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]      o_word_count
);

  localparam int BUS = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int CW = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MEM_SIZE_IN_WORDS);

  state_e         state_q, state_d;
  logic [BUS-1:0] instr_q, instr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           clear_q, write_q, busy_q, done_q, error_q;

  logic           asm_clear, asm_valid, word_valid, full, halt_pend;
  logic [BUS-1:0] word;

  // After the HALT word is latched no further bytes belong to the program.
  assign halt_pend = (state_q == S_WRITE) && (instr_q == HALT_WORD);
  assign asm_clear = i_start || (state_q == S_CLEAR);
  assign asm_valid = i_rx_valid && !halt_pend &&
                     ((state_q == S_RECV) || (state_q == S_WRITE));
  // The own count guards against a memory that never reports full.
  assign full = i_mem_full || (cnt_q == MAXC);

  byte_assembler #(
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
  ) u_asm (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (asm_clear),
    .i_valid     (asm_valid),
    .i_byte      (i_rx_data),
    .o_word      (word),
    .o_word_valid(word_valid)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d = cnt_q;
    if (i_start) begin
      state_d = S_CLEAR;
      cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_CLEAR: state_d = S_WAIT_EMPTY;
        S_WAIT_EMPTY: if (i_mem_empty) state_d = S_RECV;
        S_RECV, S_WRITE: begin
          if (state_q == S_WRITE)
            state_d = halt_pend ? S_DONE : S_RECV;
          // Full check happens as the word completes, so the strobe
          // cycle can be registered one cycle after the last byte.
          if (word_valid && !halt_pend) begin
            if (full) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_WRITE;
              instr_d = word;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      cnt_q <= '0;
      clear_q <= 1'b0;
      write_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q <= cnt_d;
      clear_q <= (state_d == S_CLEAR);
      write_q <= (state_d == S_WRITE);
      busy_q <= (state_d == S_CLEAR) || (state_d == S_WAIT_EMPTY) ||
                (state_d == S_RECV) || (state_d == S_WRITE);
      done_q <= (state_d == S_DONE);
      error_q <= (state_d == S_ERROR);
    end
  end

  assign o_clear_mem = clear_q;
  assign o_write_mem = write_q;
  assign o_instruction = instr_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_error = error_q;
  assign o_word_count = cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a write scoreboard.
// Second instance uses a 2-word memory for the overflow case.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid, full, empty;
  logic [7:0]  rx_data;

  logic        clr1, wr1, busy1, done1, err1;
  logic [31:0] ins1;
  logic [6:0]  cnt1;
  logic        clr2, wr2, busy2, done2, err2;
  logic [31:0] ins2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int clr_cnt = 0;
  int wr2_cnt = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  instruction_loader dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_mem_full(full), .i_mem_empty(empty),
    .o_clear_mem(clr1), .o_write_mem(wr1),
    .o_instruction(ins1), .o_busy(busy1),
    .o_done(done1), .o_error(err1), .o_word_count(cnt1)
  );

  instruction_loader #(.MEM_SIZE_IN_WORDS(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_mem_full(full), .i_mem_empty(empty),
    .o_clear_mem(clr2), .o_write_mem(wr2),
    .o_instruction(ins2), .o_busy(busy2),
    .o_done(done2), .o_error(err2), .o_word_count(cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (wr2) wr2_cnt++;
    if (clr1) clr_cnt++;
    if (clr1 && wr1) chk("clear_and_write", 1, 0);
    if (wr1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {32'h0, ins1}, 64'hDEAD);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("write_word", {32'h0, ins1}, {32'h0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_pulse_on", {63'h0, clr1}, 1);
    chk("busy_on_start", {63'h0, busy1}, 1);
    step();
    chk("clear_pulse_off", {63'h0, clr1}, 0);
    step();
  endtask

  initial begin
    int w0, c0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; full = 1'b0; empty = 1'b1;
    step(); step();
    chk("reset_busy", {63'h0, busy1}, 0);
    chk("reset_instr", {32'h0, ins1}, 0);
    rst = 1'b0;
    step();

    // 1: reset mid-word, then a clean load restarts at byte 0
    do_start();
    send(8'h20); send(8'h08);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_outs", {clr1, wr1, busy1, done1, err1, 7'h0, cnt1},
        64'h0);
    chk("rst_instr", {32'h0, ins1}, 0);

    // 2: single word, strobe one cycle after last byte
    c0 = clr_cnt;
    do_start();
    chk("one_clear", c0 + 1, clr_cnt);
    sb.push_back(32'h2008_0005);
    send_word(32'h2008_0005);
    chk("write_latency", {63'h0, wr1}, 1);
    chk("count_1", {57'h0, cnt1}, 1);
    chk("busy_loading", {63'h0, busy1}, 1);
    step();
    chk("write_one_cycle", {63'h0, wr1}, 0);

    // 3: program terminated by HALT
    do_start();
    w0 = wr_cnt;
    sb.push_back(32'h2008_0005);
    sb.push_back(32'hFFFF_FFFF);
    send_word(32'h2008_0005);
    send_word(32'hFFFF_FFFF);
    step();
    chk("halt_done", {done1, busy1}, 2'b10);
    chk("halt_count", {57'h0, cnt1}, 2);
    chk("halt_writes", wr_cnt - w0, 2);
    send(8'h77);
    step();
    chk("done_holds", {done1, wr1}, 2'b10);

    // 4: back-to-back bytes across the WRITE cycle
    do_start();
    w0 = wr_cnt;
    sb.push_back(32'h1122_3344);
    sb.push_back(32'h5566_7788);
    sb.push_back(32'h0A0B_0C0D);
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    send_word(32'h0A0B_0C0D);
    step();
    chk("b2b_writes", wr_cnt - w0, 3);
    chk("b2b_count", {57'h0, cnt1}, 3);

    // 5: overflow on the 2-word instance
    do_start();
    w0 = wr2_cnt;
    sb.push_back(32'hCAFE_0001);
    sb.push_back(32'hCAFE_0002);
    send_word(32'hCAFE_0001);
    send_word(32'hCAFE_0002);
    step();
    full = 1'b1;
    send_word(32'hCAFE_0003);
    chk("ovf_error", {62'h0, err2, busy2}, 2'b10);
    chk("ovf_no_strobe", {63'h0, wr2}, 0);
    chk("ovf_count", {62'h0, cnt2}, 2);
    chk("ovf_error_big", {63'h0, err1}, 1);
    step();
    chk("ovf_writes", wr2_cnt - w0, 2);
    full = 1'b0;

    // 6: start coincident with the last byte wins
    do_start();
    send(8'hAB); send(8'hCD); send(8'hEF);
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h01;
    step();
    start = 1'b0;
    rx_valid = 1'b0;
    chk("start_win_clear", {clr1, wr1}, 2'b10);
    chk("start_win_count", {57'h0, cnt1}, 0);
    chk("start_win_error", {63'h0, err1}, 0);
    step(); step();
    sb.push_back(32'h1357_9BDF);
    send_word(32'h1357_9BDF);
    chk("after_start_wr", {63'h0, wr1}, 1);
    chk("after_start_cnt", {57'h0, cnt1}, 1);
    step(); step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
